imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I side) and the memory stage (D side) of the 5-stage pipeline.
- Sequences one memory transaction at a time through a request/acknowledge handshake. Returns read data to the winning requester.
- Produces the stall_f / stall_m terms that the hazard logic ORs into StallF/StallD and the M-stage freeze.
- The D side has priority. A starvation guard prevents fetch from being locked out indefinitely.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_WAIT, 4, number of consecutive D grants taken while i_req is pending before I is forced to win (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held high until i_done
i_addr  in  ADDR_W  fetch address (PCF)
i_rdata  out  DATA_W  fetched instruction, valid while i_done=1
i_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  load/store request; held high until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address (ALUResultM)
d_wdata  in  DATA_W  store data (WriteDataM)
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse for data
stall_f  out  1  i_req & ~i_done (combinational)
stall_m  out  1  d_req & ~d_done (combinational)
mem_req  out  1  memory request, registered
mem_we  out  1  registered
mem_addr  out  ADDR_W  registered
mem_wdata  out  DATA_W  registered
mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  memory read data
perf_i_grants  out  32  see Optional Feature
perf_d_grants  out  32  see Optional Feature
perf_conflicts  out  32  see Optional Feature

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- Reset values (asynchronous):
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - i_done=0, d_done=0, i_rdata=0, d_rdata=0
  - starvation counter wait_cnt=0
  - perf counters=0
- IDLE, arbitration, evaluated at each rising edge:
  - d_req & (~i_req | wait_cnt<MAX_WAIT) -> grant D.
  - Otherwise i_req -> grant I.
  - Neither request -> stay in IDLE.
- On a grant:
  - Latch addr, we and wdata into the mem_* registers. For I: mem_we=0, mem_wdata=0.
  - Set mem_req=1 and go to BUSY_I or BUSY_D.
  - mem_req is therefore high in the cycle after the request is first seen in IDLE.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on every D grant made while i_req=1.
  - Clears to 0 on every I grant.
  - Unchanged otherwise.
- BUSY_x:
  - mem_* are held stable until mem_ack.
  - On mem_ack: mem_req<=0, capture mem_rdata into x_rdata, x_done<=1, go to DONE.
  - Stores also capture mem_rdata, which is don't-care.
- DONE:
  - Lasts exactly one cycle; x_done=1 during it.
  - The requester drops or changes req by the end of this cycle.
  - Next state is IDLE; x_done<=0.
  - No arbitration occurs in DONE.
  - Minimum turnaround is 3 cycles per transaction with a zero-wait memory (ack in the first mem_req cycle).
- x_rdata holds its value until the next completion on the same side.
- Requester inputs that change while in BUSY_x are ignored; only the latched values drive memory.
- Simultaneous i_req and d_req in IDLE: D wins unless wait_cnt==MAX_WAIT.
- A request that rises while the arbiter is BUSY_x or DONE is sampled in the next IDLE cycle.
- mem_ack while in IDLE or DONE is ignored (protocol error; no state change).
- reset asserted mid-transaction:
  - mem_req drops asynchronously.
  - The transaction is abandoned and no done pulse is generated.
  - Memory side must tolerate the dropped request.
- stall_f / stall_m are purely combinational and are never registered.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_i_grants increments on each I grant.
  - perf_d_grants increments on each D grant.
  - perf_conflicts increments on each IDLE edge where i_req & d_req are both 1.
  - All three wrap modulo 2^32 and are cleared by reset.
- Not defined: the three outputs are tied to 0 and no counter flops are built.

Test Plan:
- Single fetch, memory acks on the 1st mem_req cycle, i_addr=0x10, mem_rdata=0x00500093 -> mem_req high 1 cycle with mem_addr=0x10 and mem_we=0; i_done pulses once with i_rdata=0x00500093; stall_f=1 from i_req rise until i_done.
- Store, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, memory acks after 3 wait cycles -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF held 4 cycles; d_done pulses once; i_done stays 0.
- i_req and d_req held continuously, MAX_WAIT=4, zero-wait memory -> grant sequence D,D,D,D,I,D,D,D,D,I; wait_cnt returns to 0 after each I grant.
- reset pulsed while in BUSY_D with mem_req=1 -> mem_req=0 immediately (before the next clock edge); no d_done pulse; after release an I-only request completes normally.
- d_addr changed from 0x40 to 0x80 during BUSY_D -> mem_addr stays 0x40 until mem_ack.
- With ARB_PERF_CNT_EN defined, 5 I and 3 D transactions with 2 overlapping requests -> perf_i_grants=5, perf_d_grants=3, perf_conflicts ≥2. Without the macro -> all three read 0.

Source files
------------

// File: rtl/imem_dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_port_arbiter_if
//  Description : Bundle of requester-side and memory-side signals around the
//                I/D port arbiter.
//                  slave  : used by the arbiter. It serves the fetch and
//                           memory stages and drives the unified memory port.
//                  master : used by the surroundings, i.e. the pipeline
//                           requesters and the memory model.
//  Signals     : i_req/i_addr/i_rdata/i_done           fetch side
//                d_req/d_we/d_addr/d_wdata/d_rdata/d_done  data side
//                stall_f/stall_m                       hazard terms
//                mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory
//                perf_i_grants/perf_d_grants/perf_conflicts  statistics
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch side
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;
   // data side
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   // hazard terms
   logic              stall_f;
   logic              stall_m;
   // memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   // statistics
   logic [31:0]       perf_i_grants;
   logic [31:0]       perf_d_grants;
   logic [31:0]       perf_conflicts;

   modport slave (
      input  i_req, i_addr,
      output i_rdata, i_done,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_done,
      output stall_f, stall_m,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output perf_i_grants, perf_d_grants, perf_conflicts
   );

   modport master (
      output i_req, i_addr,
      input  i_rdata, i_done,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  stall_f, stall_m,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  perf_i_grants, perf_d_grants, perf_conflicts
   );
endinterface
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_port_arbiter
//  Description : Shares one single-ported unified memory between the fetch
//                stage (I side) and the memory stage (D side). One
//                transaction at a time: IDLE -> BUSY_I/BUSY_D -> DONE -> IDLE.
//                The D side has priority; after MAX_WAIT consecutive D grants
//                taken while a fetch was pending, the fetch is forced to win.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    imem_dmem_port_arbiter_if.slave (requesters, hazard
//                       terms, registered memory port, perf counters)
//  Parameters  : ADDR_W, DATA_W, MAX_WAIT (1..15)
//  Options     : ARB_PERF_CNT_EN - when defined, builds the three 32-bit
//                grant/conflict counters; otherwise the outputs are tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   imem_dmem_port_arbiter_if.slave   bus
);

   localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                r_i_done;
   logic                r_d_done;
   logic [3:0]          r_wait_cnt;

   logic                w_mem_req_nxt;
   logic                w_mem_we_nxt;
   logic [ADDR_W-1:0]   w_mem_addr_nxt;
   logic [DATA_W-1:0]   w_mem_wdata_nxt;
   logic [DATA_W-1:0]   w_i_rdata_nxt;
   logic [DATA_W-1:0]   w_d_rdata_nxt;
   logic                w_i_done_nxt;
   logic                w_d_done_nxt;
   logic [3:0]          w_wait_cnt_nxt;

   logic                w_grant_d;
   logic                w_grant_i;

   // Arbitration only happens in IDLE. D wins unless a fetch is pending and
   // has already been passed over MAX_WAIT times in a row.
   assign w_grant_d = (r_state == S_IDLE) && bus.d_req &&
                      (!bus.i_req || (r_wait_cnt < c_MAX_WAIT));
   assign w_grant_i = (r_state == S_IDLE) && bus.i_req && !w_grant_d;

   // ------------------------------------------------------------------------
   // State register and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_wait_cnt  <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_i_rdata   <= w_i_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_i_done    <= w_i_done_nxt;
         r_d_done    <= w_d_done_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-register logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_i_rdata_nxt   = r_i_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      w_i_done_nxt    = r_i_done;
      w_d_done_nxt    = r_d_done;
      w_wait_cnt_nxt  = r_wait_cnt;

      unique case (r_state)
         S_IDLE: begin
            if (w_grant_d) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = bus.d_we;
               w_mem_addr_nxt  = bus.d_addr;
               w_mem_wdata_nxt = bus.d_wdata;
               w_state_nxt     = S_BUSY_D;
               // Only grants that pass over a waiting fetch count toward
               // starvation.
               if (bus.i_req && (r_wait_cnt < c_MAX_WAIT)) begin
                  w_wait_cnt_nxt = r_wait_cnt + 4'd1;
               end
            end else if (w_grant_i) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = bus.i_addr;
               w_mem_wdata_nxt = '0;
               w_state_nxt     = S_BUSY_I;
               w_wait_cnt_nxt  = 4'd0;
            end
         end

         S_BUSY_I: begin
            if (bus.mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_i_rdata_nxt = bus.mem_rdata;
               w_i_done_nxt  = 1'b1;
               w_state_nxt   = S_DONE;
            end
         end

         S_BUSY_D: begin
            // Stores capture mem_rdata too; the value is simply don't-care.
            if (bus.mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_d_rdata_nxt = bus.mem_rdata;
               w_d_done_nxt  = 1'b1;
               w_state_nxt   = S_DONE;
            end
         end

         S_DONE: begin
            // One-cycle completion window; requesters drop or change their
            // request here, so no arbitration until back in IDLE.
            w_i_done_nxt = 1'b0;
            w_d_done_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.i_done    = r_i_done;
   assign bus.d_done    = r_d_done;

   // Hazard terms stay combinational so the stall releases in the same cycle
   // the done pulse is visible.
   assign bus.stall_f = bus.i_req & ~r_i_done;
   assign bus.stall_m = bus.d_req & ~r_d_done;

   // ------------------------------------------------------------------------
   // Optional statistics
   // ------------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
   logic        w_conflict;
   logic [31:0] r_perf_i_grants;
   logic [31:0] r_perf_d_grants;
   logic [31:0] r_perf_conflicts;

   assign w_conflict = (r_state == S_IDLE) && bus.i_req && bus.d_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_i_grants  <= 32'd0;
         r_perf_d_grants  <= 32'd0;
         r_perf_conflicts <= 32'd0;
      end else begin
         if (w_grant_i) r_perf_i_grants  <= r_perf_i_grants + 32'd1;
         if (w_grant_d) r_perf_d_grants  <= r_perf_d_grants + 32'd1;
         if (w_conflict) r_perf_conflicts <= r_perf_conflicts + 32'd1;
      end
   end

   assign bus.perf_i_grants  = r_perf_i_grants;
   assign bus.perf_d_grants  = r_perf_d_grants;
   assign bus.perf_conflicts = r_perf_conflicts;
`else
   assign bus.perf_i_grants  = 32'd0;
   assign bus.perf_d_grants  = 32'd0;
   assign bus.perf_conflicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_dmem_port_arbiter
//  Description : Directed self-checking bench for imem_dmem_port_arbiter.
//                A negedge memory model acks after ack_delay wait cycles and
//                returns mem_rdata = mem_rdata_val ^ mem_addr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

   localparam int c_ADDR_W   = 32;
   localparam int c_DATA_W   = 32;
   localparam int c_MAX_WAIT = 4;

   logic clk;
   logic reset;

   int          n_checks;
   int          n_errors;
   int          ack_delay;
   int          mem_cnt;
   logic [31:0] mem_rdata_val;
   logic [31:0] grants[$];

   imem_dmem_port_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

   imem_dmem_port_arbiter #(
      .ADDR_W   (c_ADDR_W),
      .DATA_W   (c_DATA_W),
      .MAX_WAIT (c_MAX_WAIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: counts mem_req cycles and acks on cycle ack_delay+1.
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      mem_cnt       = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_req) begin
            bus.mem_ack   = (mem_cnt == ack_delay);
            bus.mem_rdata = mem_rdata_val ^ bus.mem_addr;
            mem_cnt++;
         end else begin
            bus.mem_ack = 1'b0;
            mem_cnt     = 0;
         end
      end
   end

   // Grant monitor: records the address of every new memory request.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !prev) grants.push_back(bus.mem_addr);
         prev = bus.mem_req;
      end
   end

   // Both sides request at once; each drops its request in its DONE cycle.
   task automatic do_both(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] val);
      logic d_seen;
      d_seen        = 1'b0;
      mem_rdata_val = val;
      ack_delay     = 0;
      bus.i_addr    = ia;
      bus.d_addr    = da;
      bus.d_we      = 1'b0;
      bus.i_req     = 1'b1;
      bus.d_req     = 1'b1;
      for (int c = 0; c < 40 && (bus.i_req || bus.d_req); c++) begin
         step();
         if (bus.d_done) begin
            check_eq("both_d_first", {31'd0, bus.i_done}, 32'd0);
            check_eq("both_d_rdata", bus.d_rdata, val ^ da);
            d_seen    = 1'b1;
            bus.d_req = 1'b0;
         end
         if (bus.i_done) begin
            check_eq("both_i_after_d", {31'd0, d_seen}, 32'd1);
            check_eq("both_i_rdata", bus.i_rdata, val ^ ia);
            bus.i_req = 1'b0;
         end
      end
      check_eq("both_timeout", {30'd0, bus.i_req, bus.d_req}, 32'd0);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      step();
   endtask

   initial begin
      logic [31:0] exp_seq [10];
      int          cyc;

      n_checks      = 0;
      n_errors      = 0;
      ack_delay     = 0;
      mem_rdata_val = 32'd0;
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      reset         = 1'b1;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
      check_eq("rst_mem_addr",  bus.mem_addr, 32'd0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check_eq("rst_dones",     {30'd0, bus.i_done, bus.d_done}, 32'd0);
      check_eq("rst_i_rdata",   bus.i_rdata, 32'd0);
      check_eq("rst_d_rdata",   bus.d_rdata, 32'd0);
      reset = 1'b0;
      step();

      // ---- single fetch, zero-wait memory ----
      mem_rdata_val = 32'h0050_0093 ^ 32'h10;
      ack_delay     = 0;
      bus.i_addr    = 32'h10;
      bus.i_req     = 1'b1;
      #1;
      check_eq("f_stall_rise", {31'd0, bus.stall_f}, 32'd1);
      step();
      check_eq("f_mem_req",  {31'd0, bus.mem_req}, 32'd1);
      check_eq("f_mem_addr", bus.mem_addr, 32'h10);
      check_eq("f_mem_we",   {31'd0, bus.mem_we}, 32'd0);
      check_eq("f_mem_wd",   bus.mem_wdata, 32'd0);
      check_eq("f_stall_busy", {31'd0, bus.stall_f}, 32'd1);
      step();
      check_eq("f_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
      check_eq("f_i_done",   {31'd0, bus.i_done}, 32'd1);
      check_eq("f_i_rdata",  bus.i_rdata, 32'h0050_0093);
      check_eq("f_stall_done", {31'd0, bus.stall_f}, 32'd0);
      bus.i_req = 1'b0;
      step();
      check_eq("f_i_done_off", {31'd0, bus.i_done}, 32'd0);
      check_eq("f_i_rdata_hold", bus.i_rdata, 32'h0050_0093);

      // ---- store with 3 wait cycles; d_addr changes mid-transaction ----
      mem_rdata_val = 32'h1111_1111;
      ack_delay     = 3;
      bus.d_we      = 1'b1;
      bus.d_addr    = 32'h40;
      bus.d_wdata   = 32'hDEAD_BEEF;
      bus.d_req     = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq($sformatf("s_mem_req%0d", k),  {31'd0, bus.mem_req}, 32'd1);
         check_eq($sformatf("s_mem_we%0d", k),   {31'd0, bus.mem_we}, 32'd1);
         check_eq($sformatf("s_mem_addr%0d", k), bus.mem_addr, 32'h40);
         check_eq($sformatf("s_mem_wd%0d", k),   bus.mem_wdata, 32'hDEAD_BEEF);
         check_eq($sformatf("s_done%0d", k),     {30'd0, bus.i_done, bus.d_done}, 32'd0);
         check_eq($sformatf("s_stall_m%0d", k),  {31'd0, bus.stall_m}, 32'd1);
         if (k == 2) begin
            bus.d_addr  = 32'h80;
            bus.d_wdata = 32'h0;
         end
      end
      step();
      check_eq("s_d_done",   {31'd0, bus.d_done}, 32'd1);
      check_eq("s_i_done",   {31'd0, bus.i_done}, 32'd0);
      check_eq("s_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
      check_eq("s_stall_m_done", {31'd0, bus.stall_m}, 32'd0);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      step();
      check_eq("s_d_done_off", {31'd0, bus.d_done}, 32'd0);

      // ---- starvation guard: both held, zero-wait memory ----
      grants.delete();
      ack_delay     = 0;
      mem_rdata_val = 32'h0;
      bus.i_addr    = 32'h100;
      bus.d_addr    = 32'h200;
      bus.d_we      = 1'b0;
      bus.i_req     = 1'b1;
      bus.d_req     = 1'b1;
      exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100,
                  32'h200, 32'h200, 32'h200, 32'h200, 32'h100};
      cyc = 0;
      while (grants.size() < 10 && cyc < 200) begin
         step();
         cyc++;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      check_eq("g_count", (grants.size() >= 10) ? 32'd10 : grants.size(), 32'd10);
      for (int k = 0; k < 10; k++) begin
         check_eq($sformatf("g_seq%0d", k),
                  (k < grants.size()) ? grants[k] : 32'hFFFF_FFFF, exp_seq[k]);
      end
      repeat (4) step();
      check_eq("g_idle", {31'd0, bus.mem_req}, 32'd0);

      // ---- reset during BUSY_D ----
      ack_delay  = 10;
      bus.d_addr = 32'h300;
      bus.d_req  = 1'b1;
      step();
      check_eq("r_mem_req_busy", {31'd0, bus.mem_req}, 32'd1);
      step();
      #1;
      reset = 1'b1;
      #1;
      check_eq("r_mem_req_async", {31'd0, bus.mem_req}, 32'd0);
      check_eq("r_d_done_async",  {31'd0, bus.d_done}, 32'd0);
      bus.d_req = 1'b0;
      step();
      reset = 1'b0;
      step();
      check_eq("r_d_done_after", {31'd0, bus.d_done}, 32'd0);
      check_eq("r_mem_req_after", {31'd0, bus.mem_req}, 32'd0);

      // ---- fetch after reset, one wait cycle ----
      ack_delay     = 1;
      mem_rdata_val = 32'hCAFE_F00D ^ 32'h20;
      bus.i_addr    = 32'h20;
      bus.i_req     = 1'b1;
      step();
      check_eq("p_mem_addr", bus.mem_addr, 32'h20);
      step();
      check_eq("p_wait", {30'd0, bus.mem_req, bus.i_done}, 32'd2);
      step();
      check_eq("p_i_done",  {31'd0, bus.i_done}, 32'd1);
      check_eq("p_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
      bus.i_req = 1'b0;
      step();

      // ---- overlapping requests ----
      do_both(32'h400, 32'h500, 32'h1234_0000);
      do_both(32'h600, 32'h700, 32'h5678_0000);

      // ---- statistics since the last reset: 3 I, 2 D, 2 conflicts ----
`ifdef ARB_PERF_CNT_EN
      check_eq("perf_i", bus.perf_i_grants,  32'd3);
      check_eq("perf_d", bus.perf_d_grants,  32'd2);
      check_eq("perf_c", bus.perf_conflicts, 32'd2);
`else
      check_eq("perf_i", bus.perf_i_grants,  32'd0);
      check_eq("perf_d", bus.perf_d_grants,  32'd0);
      check_eq("perf_c", bus.perf_conflicts, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
